// File: rtl/present_sbox_layer_pkg.sv
// Shared definitions for the PRESENT S-box layer: substitution tables and FSM state encoding.
// Table nibble x lives at bits [4*x +: 4], so entry 0 is the least significant nibble.
package present_sbox_layer_pkg;

   localparam logic [63:0] PRESENT_SBOX     = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] PRESENT_SBOX_INV = 64'hA970_364B_D21C_8FE5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/present_sbox_layer_unit.sv
// Single 4-bit PRESENT S-box with a select between the forward and inverse tables.
// Purely combinational; several copies run in parallel inside the layer.
module present_sbox_unit
   import present_sbox_layer_pkg::*;
(
   input  logic [3:0] i_nib,
   input  logic       i_inv,
   output logic [3:0] o_nib
);

   logic [63:0] w_table;

   assign w_table = i_inv ? PRESENT_SBOX_INV : PRESENT_SBOX;

   // Every nibble value is listed so the lookup never holds a previous value.
   always_comb begin
      o_nib = 4'h0;
      case (i_nib)
         4'h0: o_nib = w_table[ 3: 0];
         4'h1: o_nib = w_table[ 7: 4];
         4'h2: o_nib = w_table[11: 8];
         4'h3: o_nib = w_table[15:12];
         4'h4: o_nib = w_table[19:16];
         4'h5: o_nib = w_table[23:20];
         4'h6: o_nib = w_table[27:24];
         4'h7: o_nib = w_table[31:28];
         4'h8: o_nib = w_table[35:32];
         4'h9: o_nib = w_table[39:36];
         4'hA: o_nib = w_table[43:40];
         4'hB: o_nib = w_table[47:44];
         4'hC: o_nib = w_table[51:48];
         4'hD: o_nib = w_table[55:52];
         4'hE: o_nib = w_table[59:56];
         4'hF: o_nib = w_table[63:60];
         default: o_nib = 4'h0;
      endcase
   end

endmodule

// File: rtl/present_sbox_layer.sv
// Multi-cycle PRESENT sBoxLayer: substitutes NIB_PER_CYC nibbles per clock, LSB chunk first,
// in forward or inverse mode, with a valid/ready handshake on both sides.
module present_sbox_layer
   import present_sbox_layer_pkg::*;
#(
   parameter int STATE_W     = 64,
   parameter int NIB_PER_CYC = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_data,
   input  logic               in_inv,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_data,
   output logic               busy
);

   localparam int CHUNK_W = 4 * NIB_PER_CYC;
   localparam int CYC     = STATE_W / CHUNK_W;
   localparam int CNT_W   = (CYC > 1) ? $clog2(CYC) : 1;

   generate
      if ((NIB_PER_CYC < 1) || (STATE_W % CHUNK_W != 0)) begin : g_badParam
         $error("present_sbox_layer: STATE_W must be a multiple of 4*NIB_PER_CYC");
      end
   endgenerate

   state_t             r_state;
   state_t             w_nextState;
   logic [STATE_W-1:0] r_data;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_mode;
   logic [CHUNK_W-1:0] w_chunk;
   logic [CHUNK_W-1:0] w_subChunk;
   logic               w_lastChunk;

   assign w_chunk     = r_data[int'(r_cnt) * CHUNK_W +: CHUNK_W];
   assign w_lastChunk = (r_cnt == CNT_W'(CYC - 1));

   generate
      for (genvar gi = 0; gi < NIB_PER_CYC; gi++) begin : g_unit
         present_sbox_unit u_sbox (
            .i_nib (w_chunk[gi*4 +: 4]),
            .i_inv (r_mode),
            .o_nib (w_subChunk[gi*4 +: 4])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)    w_nextState = S_BUSY;
         S_BUSY:  if (w_lastChunk) w_nextState = S_DONE;
         S_DONE:  if (out_ready)   w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Mode and data are captured only at acceptance, so input changes later are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_cnt  <= '0;
         r_mode <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_data <= in_data;
                  r_mode <= in_inv;
                  r_cnt  <= '0;
               end
            end
            S_BUSY: begin
               r_data[int'(r_cnt) * CHUNK_W +: CHUNK_W] <= w_subChunk;
               if (!w_lastChunk) r_cnt <= r_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_BUSY);
   assign out_valid = (r_state == S_DONE);
   assign out_data  = r_data;

endmodule
